// File: rtl/ivt_pkg.sv
// ivt_pkg: shared types for the interval timer arbiter.
//   ivt_state_t  FSM state encoding (IDLE / RUN / DONE)
//   NREQ         number of requesters sharing the counter
//   req_idx_t    requester index
//   ivt_onehot   index -> one-hot requester vector
package ivt_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IVT_IDLE = 2'd0,
    IVT_RUN  = 2'd1,
    IVT_DONE = 2'd2
  } ivt_state_t;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;

  function automatic logic [NREQ-1:0] ivt_onehot(input req_idx_t id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ivt_tcounter.sv
// ivt_tcounter: WIDTH-bit synchronous up-counter built from toggle flops.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset (count -> 0)
//   i_clr    synchronous clear, wins over i_en
//   i_en     count enable
//   o_count  current count
module ivt_tcounter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_tog;

  // Bit i toggles when every lower bit is 1.
  assign w_tog[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tog
    assign w_tog[gi] = &r_count[gi-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count ^ w_tog;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter: two requesters share one toggle-flop interval
// counter through a round-robin arbiter and a small sequencing FSM.
// Optional build macro: IVT_PERIODIC_EN (a sole requester that keeps its
// request high re-runs straight from DONE with no IDLE gap).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   req[1:0]   level requests, held until done or abort
//   len0/len1  interval lengths, sampled when the grant is made
//   gnt[1:0]   one-hot grant, first RUN cycle through DONE cycle
//   done[1:0]  one-cycle completion pulse to the granted requester
//   busy       FSM not in IDLE
//   count      shared counter value
//
// state    | meaning
// IVT_IDLE | counter cleared, arbitrate among requests
// IVT_RUN  | counting up to the latched length
// IVT_DONE | pulse done, then release (or re-run when periodic)
module interval_timer_arbiter
  import ivt_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  ivt_state_t       r_state;
  ivt_state_t       w_next;
  req_idx_t         r_last;
  req_idx_t         r_win;
  logic [WIDTH-1:0] r_len;

  req_idx_t         w_pick;
  req_idx_t         w_latch_id;
  logic             w_latch;
  logic             w_set_last;
  logic [WIDTH-1:0] w_len_sel;
  logic             w_clr;
  logic             w_en;

  // On a tie the requester that was not served last wins.
  assign w_pick    = (req[0] && req[1]) ? ~r_last : req_idx_t'(req[1]);
  assign w_len_sel = (w_latch_id == req_idx_t'(1)) ? len1 : len0;

  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_latch_id = r_win;
    w_set_last = 1'b0;
    case (r_state)
      IVT_IDLE: begin
        if (|req) begin
          w_next     = IVT_RUN;
          w_latch    = 1'b1;
          w_latch_id = w_pick;
        end
      end
      IVT_RUN: begin
        // Losing the request aborts silently, even on the terminal count.
        if (!req[r_win]) begin
          w_next     = IVT_IDLE;
          w_set_last = 1'b1;
        end else if (count == r_len) begin
          w_next = IVT_DONE;
        end
      end
      IVT_DONE: begin
        w_set_last = 1'b1;
`ifdef IVT_PERIODIC_EN
        if (req[r_win] && !req[~r_win]) begin
          w_next  = IVT_RUN;
          w_latch = 1'b1;
        end else begin
          w_next = IVT_IDLE;
        end
`else
        w_next = IVT_IDLE;
`endif
      end
      default: w_next = IVT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IVT_IDLE;
      r_last  <= req_idx_t'(1);
      r_win   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_win <= w_latch_id;
        r_len <= w_len_sel;
      end
      if (w_set_last) begin
        r_last <= r_win;
      end
    end
  end

  // Clear on every entry to RUN and on every exit to IDLE; the RUN->DONE
  // edge neither clears nor counts so DONE shows the final value.
  assign w_clr = (r_state != IVT_RUN) || (w_next == IVT_IDLE);
  assign w_en  = (r_state == IVT_RUN) && (w_next == IVT_RUN);

  ivt_tcounter #(
    .WIDTH (WIDTH)
  ) u_tcounter (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (count)
  );

  assign busy = (r_state != IVT_IDLE);
  assign gnt  = busy ? ivt_onehot(r_win) : '0;
  assign done = (r_state == IVT_DONE) ? ivt_onehot(r_win) : '0;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
module tb_interval_timer_arbiter;

  localparam int WIDTH = 3;

  logic             clk;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] count;

  interval_timer_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one active interval described by who, how long and
  // the cycle its counting started; everything else is arithmetic on cyc.
  bit m_busy = 0;
  int m_id   = 0;
  int m_len  = 0;
  int m_start = 0;
  int m_last = 1;

  typedef struct { int id; int at; } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic start_run(input int id, input int c);
    m_busy  = 1;
    m_id    = id;
    m_len   = (id == 1) ? int'(len1) : int'(len0);
    m_start = c + 1;
    sb_q.push_back('{id, c + m_len + 2});
  endtask

  // Called at each active edge with the inputs the DUT is sampling.
  task automatic model_step();
    int c, k, id;
    c = cyc;
    if (!m_busy) begin
      if (req != 2'b00) begin
        if (req == 2'b11) id = 1 - m_last;
        else              id = req[1] ? 1 : 0;
        start_run(id, c);
      end
    end else begin
      k = c - m_start;
      if (k <= m_len) begin
        if (!req[m_id]) begin
          m_busy = 0;
          m_last = m_id;
          if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
      end else begin
        m_last = m_id;
        m_busy = 0;
`ifdef IVT_PERIODIC_EN
        if (req[m_id] && !req[1 - m_id]) start_run(m_id, c);
`endif
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_last = 1;
    sb_q.delete();
  endtask

  task automatic tick(input logic [1:0] r, input int l0, input int l1);
    req  = r;
    len0 = WIDTH'(l0);
    len1 = WIDTH'(l1);
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic hold(input logic [1:0] r, input int l0, input int l1, input int n);
    for (int i = 0; i < n; i++) tick(r, l0, l1);
  endtask

  // Monitor: per-cycle grant/count/busy against the model, and done pulses
  // popped from the scoreboard as the DUT presents them.
  initial begin
    int k, eg, ec, eb;
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_busy) begin
        k  = cyc - m_start;
        eg = 1 << m_id;
        eb = 1;
        ec = (k <= m_len) ? k : m_len;
      end else begin
        eg = 0; eb = 0; ec = 0;
      end
      chk("gnt", int'(gnt), eg);
      chk("busy", int'(busy), eb);
      chk("count", int'(count), ec);
      if (done != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", int'(done), 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_id", int'(done), 1 << e.id);
          chk("done_cycle", cyc, e.at);
        end
      end else if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
        e = sb_q.pop_front();
        chk("done_missing", int'(done), 1 << e.id);
      end
    end
  end

  initial begin
    bit hit;
    logic [1:0] rq;
    reset = 1'b0;
    req   = 2'b00;
    len0  = '0;
    len1  = '0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single requester, len 5.
    hold(2'b01, 5, 0, 9);
    hold(2'b00, 0, 0, 2);
    // Tie, then requester 1 alone.
    hold(2'b11, 2, 3, 5);
    hold(2'b10, 2, 3, 7);
    hold(2'b00, 0, 0, 2);
    // Zero length.
    hold(2'b01, 0, 0, 3);
    hold(2'b00, 0, 0, 2);
    // Abort at count 2, then a tie goes to requester 0.
    hold(2'b10, 0, 6, 3);
    hold(2'b00, 0, 6, 2);
    hold(2'b11, 1, 1, 4);
    hold(2'b00, 0, 0, 2);
    // Full-scale length, held long enough for several periods.
    hold(2'b01, 7, 0, 30);
    hold(2'b00, 0, 0, 2);
    // Lengths changing every cycle after the grant.
    for (int i = 0; i < 8; i++) tick(2'b01, i, 7 - i);
    hold(2'b00, 0, 0, 3);

    // Asynchronous reset between edges while counting.
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      tick(2'b01, 6, 0);
      if (count == 3'd3) hit = 1;
    end
    chk("reach_count3", int'(hit), 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_count", int'(count), 0);
    #1 reset = 1'b1;
    hold(2'b00, 0, 0, 2);

    // Randomised traffic.
    rq = 2'b00;
    for (int i = 0; i < 500; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (rq[r]) begin
          if ($urandom_range(7) == 0) rq[r] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          rq[r] = 1'b1;
        end
      end
      tick(rq, $urandom_range(7), $urandom_range(7));
    end
    hold(2'b00, 0, 0, 12);

    @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interval_timer_arbiter.md
Name: interval_timer_arbiter

Overview:
Shares one WIDTH-bit T-flip-flop interval counter between two requesters, each timing an interval of programmable length. A round-robin arbiter picks a requester. A small FSM then sequences the shared counter: clear, count up to the latched length, pulse done, release. It sits between client logic and the toggle-flop counter datapath, so several clients can time events without duplicating counters.

Parameters:
WIDTH, 3, counter and interval-length width in bits (max interval 2^WIDTH-1 counts)

Ports:
clk     input   1      system clock, rising edge
reset   input   1      asynchronous, active-low reset (0 = reset asserted)
req     input   2      per-requester interval request, level; held until done or abort
len0    input   WIDTH  interval length for requester 0, sampled at grant
len1    input   WIDTH  interval length for requester 1, sampled at grant
gnt     output  2      one-hot grant, high from first RUN cycle through DONE cycle
done    output  2      one-cycle completion pulse to the granted requester
busy    output  1      high whenever FSM not in IDLE
count   output  WIDTH  current shared counter value

Behaviour:
- Reset (reset=0, asynchronous, any state) forces:
  - state=IDLE
  - gnt=00, done=00, busy=0, count=0
  - round-robin pointer last=1, so requester 0 wins the first tie
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - count=0.
  - If any req bit is high, grant the requester not equal to last when both request; otherwise grant the sole requester.
  - Latch the winner's len into len_l, record win_id, and go to RUN next cycle.
- RUN:
  - gnt[win_id]=1.
  - If count==len_l, go to DONE next cycle and hold count.
  - Otherwise count increments by 1 using T-flop semantics: bit i toggles when bits [i-1:0] are all 1.
  - If req[win_id] drops during RUN, abort: go to IDLE next cycle, no done pulse, gnt=00, last<=win_id.
- DONE:
  - done[win_id]=1 for exactly one cycle; gnt held; count held.
  - last<=win_id; go to IDLE next cycle.
- Latency: req sampled in IDLE at cycle t gives:
  - gnt at t+1
  - count=k at t+1+k
  - done at t+len_l+2
  - gnt low at t+len_l+3
- len=0 gives done at t+2, with no special case.
- count never wraps: the maximum value len_l=2^WIDTH-1 is reached exactly, then held.
- Back-to-back requests always pass through one IDLE cycle.
- Under continuous contention the grants alternate 0,1,0,1.
- len0/len1 changes after grant have no effect.
- req of the non-granted requester is ignored until IDLE.

Optional Feature:
IVT_PERIODIC_EN
- Defined:
  - In DONE, if req[win_id] is still high and the other req is low, go directly to RUN with count=0.
  - len is re-latched and gnt stays high, giving a periodic pulse of period len_l+2 with no IDLE gap.
  - If the other requester is requesting, behave as not defined (fairness preserved).
- Undefined: DONE always returns to IDLE.

Decomposition:
- Package ivt_pkg holds:
  - state typedef (IVT_IDLE=2'd0, IVT_RUN=2'd1, IVT_DONE=2'd2)
  - NREQ=2
  - requester index typedef
- One sub-module, ivt_tcounter: WIDTH-bit synchronous T-flip-flop up-counter with sync clear and enable inputs, asynchronous active-low reset.
- Arbiter and FSM stay in the top module.

Test Plan:
1. Async reset mid-RUN: reset=0 between edges at count=3 -> gnt=00, busy=0, count=0 immediately, before next edge.
2. req=01, len0=5, req at cycle 0 -> gnt=01 cycles 1..7; count 0..5 over cycles 1..6; done=01 only at cycle 7; gnt=00 at cycle 8.
3. req=11 at cycle 0, len0=2, len1=3, req0 dropped at cycle 5 -> done=01 at cycle 4; IDLE cycle 5; gnt=10 cycles 6..10; done=10 at cycle 10.
4. req=01, len0=0 -> gnt=01 cycles 1..2; count stays 0; done=01 at cycle 2.
5. Abort: req=10, len1=6, req1 dropped when count=2 -> IDLE next cycle, gnt=00, done never asserted; next tie grants requester 0.
6. WIDTH=3, len0=7 -> count reaches 7 with no wrap, done at cycle 9; with IVT_PERIODIC_EN and req0 held, done=01 at cycles 9, 18, 27.
